// File: rtl/instruction_fetch_pkg.sv
// Shared constants, fault codes and fetch-FSM encodings for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam int unsigned LENGTH           = 32;
  localparam int unsigned INST_MEM_ADDRESS = 6;
  localparam int unsigned INST_MEM_LENGTH  = 64;

  localparam logic [LENGTH-1:0] INST_MEM_BYTES   = LENGTH'(INST_MEM_LENGTH * 4);
  localparam logic [LENGTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [LENGTH-1:0] NOP_INST         = 32'h0000_0000;

  typedef enum logic [1:0] {
    FaultNone     = 2'b00,
    FaultMisalign = 2'b01,
    FaultRange    = 2'b10
  } fetch_fault_e;

  typedef enum logic [1:0] {
    IfStStart = 2'b00,
    IfStRun   = 2'b01,
    IfStHalt  = 2'b10
  } if_state_e;

  // Misalignment takes precedence over range; the compare uses the full target width.
  function automatic fetch_fault_e target_fault(input logic [LENGTH-1:0] target);
    if (target[1:0] != 2'b00) begin
      return FaultMisalign;
    end else if (target >= INST_MEM_BYTES) begin
      return FaultRange;
    end
    return FaultNone;
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: clear drops valid and keeps data, hold freezes everything.
module if_id_register
  import instruction_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              clear,
  input  logic [LENGTH-1:0] d_pc,
  input  logic [LENGTH-1:0] d_pc_plus4,
  input  logic [LENGTH-1:0] d_instruction,
  output logic [LENGTH-1:0] q_pc,
  output logic [LENGTH-1:0] q_pc_plus4,
  output logic [LENGTH-1:0] q_instruction,
  output logic              q_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_pc          <= '0;
      q_pc_plus4    <= '0;
      q_instruction <= NOP_INST;
      q_valid       <= 1'b0;
    end else if (clear) begin
      q_valid <= 1'b0;
    end else if (!hold) begin
      q_pc          <= d_pc;
      q_pc_plus4    <= d_pc_plus4;
      q_instruction <= d_instruction;
      q_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and fills IF/ID.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [LENGTH-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       ADDR_W   = INST_MEM_ADDRESS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [LENGTH-1:0] redirect_target,
  output logic [ADDR_W+1:2] im_address,
  input  logic [LENGTH-1:0] im_instruction,
  output logic [LENGTH-1:0] if_pc,
  output logic [LENGTH-1:0] if_pc_plus4,
  output logic [LENGTH-1:0] if_instruction,
  output logic              if_valid,
  output logic [1:0]        fetch_fault,
  output logic [31:0]       fetch_count
);

  if_state_e         state_q, state_d;
  fetch_fault_e      fault_q, fault_d, redirect_fault;
  logic [LENGTH-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]       count_q, count_d;
  logic              ifid_hold, ifid_clear;

  assign pc_plus4       = pc_q + 32'd4;
  assign redirect_fault = target_fault(redirect_target);
  assign im_address     = pc_q[ADDR_W+1:2];
  assign fetch_fault    = fault_q;
  assign fetch_count    = count_q;

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    pc_d       = pc_q;
    count_d    = count_q;
    ifid_hold  = 1'b0;
    ifid_clear = 1'b0;
    unique case (state_q)
      IfStStart, IfStHalt: begin
        ifid_clear = 1'b1;
        if (state_q == IfStStart) state_d = IfStRun;
        if (redirect_valid) begin
          fault_d = redirect_fault;
          if (redirect_fault == FaultNone) begin
            pc_d    = redirect_target;
            state_d = IfStRun;
          end else begin
            state_d = IfStHalt;
          end
        end
      end
      IfStRun: begin
        if (redirect_valid) begin
          ifid_clear = 1'b1;
          fault_d    = redirect_fault;
          if (redirect_fault == FaultNone) pc_d = redirect_target;
          else                             state_d = IfStHalt;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else begin
          count_d = count_q + 32'd1;
          // The final word is still captured before halting on the end of memory.
          if (pc_plus4 == INST_MEM_BYTES) begin
            state_d = IfStHalt;
            fault_d = FaultRange;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      default: begin
        state_d    = IfStHalt;
        ifid_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IfStStart;
      fault_q <= FaultNone;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_register u_if_id_register (
    .clk           (clk),
    .rst           (rst),
    .hold          (ifid_hold),
    .clear         (ifid_clear),
    .d_pc          (pc_q),
    .d_pc_plus4    (pc_plus4),
    .d_instruction (im_instruction),
    .q_pc          (if_pc),
    .q_pc_plus4    (if_pc_plus4),
    .q_instruction (if_instruction),
    .q_valid       (if_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch against a 64-word memory holding 0x1000_0000 + index.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic [7:2]  im_address;
  logic [31:0] im_instruction;
  logic [31:0] if_pc, if_pc_plus4, if_instruction;
  logic        if_valid;
  logic [1:0]  fetch_fault;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] count;
  } capture_t;

  capture_t    exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_count = '0;

  always #5 clk = ~clk;

  assign im_instruction = 32'h1000_0000 + {26'b0, im_address};

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .im_address      (im_address),
    .im_instruction  (im_instruction),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_instruction  (if_instruction),
    .if_valid        (if_valid),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] count);
    capture_t c;
    c.pc    = pc;
    c.instr = 32'h1000_0000 + (pc >> 2);
    c.count = count;
    exp_q.push_back(c);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
    check({tag, "_pc"}, if_pc, 32'd0);
    check({tag, "_pc4"}, if_pc_plus4, 32'd0);
    check({tag, "_instr"}, if_instruction, 32'd0);
    check({tag, "_fault"}, {30'b0, fetch_fault}, 32'd0);
    check({tag, "_count"}, fetch_count, 32'd0);
    check({tag, "_addr"}, {26'b0, im_address}, 32'd0);
  endtask

  // Monitor: a new capture is a valid IF/ID whose capture counter has moved.
  always @(negedge clk) begin
    if (if_valid && fetch_count != last_count) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_capture: got pc 0x%08h, want none", if_pc);
      end else begin
        capture_t c;
        c = exp_q.pop_front();
        check("cap_pc", if_pc, c.pc);
        check("cap_pc4", if_pc_plus4, c.pc + 32'd4);
        check("cap_instr", if_instruction, c.instr);
        check("cap_count", fetch_count, c.count);
      end
    end
    last_count <= fetch_count;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    tick(); tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Free run: one START bubble then three sequential captures.
    push(32'h0, 1); push(32'h4, 2); push(32'h8, 3);
    tick();
    check("start_bubble", {31'b0, if_valid}, 32'd0);
    tick(); tick(); tick();
    check("run_count", fetch_count, 32'd3);

    // Stall for two cycles with if_pc = 8.
    stall = 1'b1;
    tick(); tick();
    check("stall_addr", {26'b0, im_address}, 32'd3);
    check("stall_pc", if_pc, 32'h8);
    check("stall_count", fetch_count, 32'd3);
    check("stall_valid", {31'b0, if_valid}, 32'd1);
    stall = 1'b0;
    push(32'hC, 4);
    tick();

    // Redirect overrides a simultaneous stall.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    check("redir_bubble", {31'b0, if_valid}, 32'd0);
    check("redir_addr", {26'b0, im_address}, 32'd16);
    stall = 1'b0; redirect_valid = 1'b0;
    push(32'h40, 5);
    tick();

    // Misaligned redirect halts; stall and time do not revive it.
    redirect_valid = 1'b1; redirect_target = 32'h42;
    tick();
    check("mis_fault", {30'b0, fetch_fault}, 32'd1);
    check("mis_valid", {31'b0, if_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("halt_valid", {31'b0, if_valid}, 32'd0);
    check("halt_fault", {30'b0, fetch_fault}, 32'd1);
    check("halt_count", fetch_count, 32'd5);
    redirect_valid = 1'b1; redirect_target = 32'h20;
    tick();
    check("recover_fault", {30'b0, fetch_fault}, 32'd0);
    redirect_valid = 1'b0;
    push(32'h20, 6);
    tick();

    // Out-of-range redirect, then sequential run off the end of memory.
    redirect_valid = 1'b1; redirect_target = 32'h100;
    tick();
    check("range_fault", {30'b0, fetch_fault}, 32'd2);
    redirect_target = 32'hF8;
    tick();
    redirect_valid = 1'b0;
    check("f8_fault", {30'b0, fetch_fault}, 32'd0);
    push(32'hF8, 7); push(32'hFC, 8);
    tick(); tick();
    check("end_valid", {31'b0, if_valid}, 32'd1);
    check("end_instr", if_instruction, 32'h1000_003F);
    check("end_fault", {30'b0, fetch_fault}, 32'd2);
    tick();
    check("end_halt_valid", {31'b0, if_valid}, 32'd0);

    // Fresh reset, run to five captures, then reset mid-run.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    push(32'h0, 1); push(32'h4, 2); push(32'h8, 3); push(32'hC, 4); push(32'h10, 5);
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_valid", {31'b0, if_valid}, 32'd1);
    check("pre_rst_count", fetch_count, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midrst");
    tick();
    check("midrst_bubble", {31'b0, if_valid}, 32'd0);
    push(32'h0, 1);
    tick();
    tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
